sseg_display_arbiter: RTL and testbench
=======================================

# sseg_display_arbiter

Shares the 4-digit seven-segment display between two independent requesters (e.g. the operand-entry path and the result path of an FSMD such as the Fibonacci circuit). It grants ownership with a round-robin policy and guarantees a minimum on-screen hold time per grant. It registers the owner's 16-bit value and drives the four hex nibbles consumed by the display multiplexer. It sits between the datapath/FSMD outputs and the sseg mux, in the same clock domain.

## Interface
- HOLD_WIDTH, 26: width of the hold counter.
- HOLD_CYCLES, 50_000_000: minimum clk cycles a grant is held (0.5 s at 100 MHz). Must be ≥1 and < 2^HOLD_WIDTH.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 wants the display; level-sensitive.
- req1  input  1  requester 1 wants the display; level-sensitive.
- data0  input  16  requester 0 value, hex digit 3 in [15:12] … digit 0 in [3:0].
- data1  input  16  requester 1 value, same packing.
- grant0  output  1  requester 0 owns the display (registered).
- grant1  output  1  requester 1 owns the display (registered).
- busy  output  1  grant0 | grant1.
- hex0, hex1, hex2, hex3  output  4 each  displayed nibbles, hex0 = [3:0] … hex3 = [15:12] of the display register.

## Operation
- States: IDLE, OWN0, OWN1. grant0 = (state==OWN0); grant1 = (state==OWN1). Grants are never both high.
- Reset (sampled on a clk edge): state IDLE; grants 0; busy 0; display register 16'h0000 (hex0..hex3 = 0); hold counter 0; round-robin pointer = requester 0 preferred.
- IDLE: if only one req is high, go to that OWNx. If both are high, go to the pointer's preferred requester. If neither, stay; the display register keeps its last value.
- On entering OWNx: load hold counter with HOLD_CYCLES-1, load display register from datax, set the pointer to prefer the other requester.
- In OWNx: the display register reloads datax every cycle (live tracking). The hold counter decrements and saturates at 0.
- Release rules in OWNx once the counter is 0:
  - Other req high: hand off directly to OWN(other), with the same entry actions. There is no IDLE gap.
  - Own req low and other req low: go to IDLE.
  - Own req high and other req low: stay; the counter remains 0.
- Before the counter reaches 0, req changes are ignored. Ownership persists even if the owner drops req.
- Reset asserted mid-grant aborts ownership immediately, per the reset values above.

## Timing
- Request-to-grant latency: a req high sampled at edge N gives grant high after edge N.
- In the same cycle, hex reflects data sampled at edge N. data-to-hex latency while owning is 1 cycle.
- A grant lasts at least HOLD_CYCLES cycles.
- Handoff: the first cycle with counter 0 and the other req high is the last cycle of the old grant. The next cycle has the new grant high and the new data on hex.
- IDLE to grant with both reqs high: the pointer is honoured. After reset, requester 0 wins.
- HOLD_CYCLES=1: the counter loads 0, so a handoff is possible after a 1-cycle grant.

## Configuration
- SSEG_ARB_PREEMPT_EN
  - Defined: requester 1 is high priority. If req1 is high while in OWN0, the block moves to OWN1 on the next edge regardless of the hold counter, with normal entry actions. OWN1 is never preempted. In IDLE with both reqs high, OWN1 wins regardless of the pointer.
  - Undefined: pure round-robin with the hold guarantee described above.

## Test plan
HOLD_CYCLES=4 unless noted.
- Reset, then idle: hex0..hex3 = 0, grant0 = grant1 = busy = 0 for 10 cycles.
- req0=1, data0=16'h1234 at cycle N → grant0 = 1 from N+1; hex3..hex0 = 1,2,3,4. data0 changes to 16'h0009 at cycle M → hex0 = 9 at M+1.
- Both reqs high from reset, data0=16'h0A0A, data1=16'h5555:
  - grant0 holds for exactly 4 cycles, then grant1 for 4 cycles, alternating.
  - hex switches in the same cycle as the grant.
  - Grants are never both high.
- req0 pulses for 1 cycle → grant0 stays high for 4 cycles, then the block returns to IDLE and hex keeps 16'h… of data0.
- Reset asserted on the 2nd cycle of an OWN1 grant → next cycle all outputs at reset values. The next simultaneous request grants requester 0.
- With SSEG_ARB_PREEMPT_EN, HOLD_CYCLES=8: req0 granted, req1 rises on the 2nd grant cycle → grant1 high the following cycle. grant1 is held ≥8 cycles despite req0.

Source files
------------

// File: rtl/sseg_display_arbiter.sv
// Round-robin arbiter that shares the 4-digit seven-segment display between two requesters with a minimum hold time per grant.
// Optional feature: define SSEG_ARB_PREEMPT_EN to make requester 1 high priority, so it preempts requester 0.
module sseg_display_arbiter #(
    parameter int HOLD_WIDTH  = 26,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic        grant0,
    output logic        grant1,
    output logic        busy,
    output logic [3:0]  hex0,
    output logic [3:0]  hex1,
    output logic [3:0]  hex2,
    output logic [3:0]  hex3
);

`ifdef SSEG_ARB_PREEMPT_EN
    localparam logic PREEMPT_EN = 1'b1;
`else
    localparam logic PREEMPT_EN = 1'b0;
`endif

    localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ZERO = {HOLD_WIDTH{1'b0}};
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = HOLD_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
    logic [15:0]            disp_q, disp_d;
    logic                   ptr_q, ptr_d;   // 1'b0 prefers requester 0
    logic                   enter0_s, enter1_s;
    logic                   hold_done_s;

    // Next-state, hold counter, display and round-robin pointer logic
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        disp_d      = disp_q;
        ptr_d       = ptr_q;
        enter0_s    = 1'b0;
        enter1_s    = 1'b0;
        hold_done_s = (hold_q == HOLD_ZERO);

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    if (PREEMPT_EN || ptr_q) begin
                        enter1_s = 1'b1;
                    end else begin
                        enter0_s = 1'b1;
                    end
                end else if (req0) begin
                    enter0_s = 1'b1;
                end else if (req1) begin
                    enter1_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0: begin
                disp_d = data0;
                hold_d = hold_done_s ? HOLD_ZERO : (hold_q - HOLD_ONE);
                if (req1 && (PREEMPT_EN || hold_done_s)) begin
                    enter1_s = 1'b1;
                end else if (hold_done_s && !req0) begin
                    state_d = IDLE;
                end else begin
                    state_d = OWN0;
                end
            end
            OWN1: begin
                disp_d = data1;
                hold_d = hold_done_s ? HOLD_ZERO : (hold_q - HOLD_ONE);
                if (hold_done_s && req0) begin
                    enter0_s = 1'b1;
                end else if (hold_done_s && !req1) begin
                    state_d = IDLE;
                end else begin
                    state_d = OWN1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entry actions are shared by grants from IDLE, handoffs and preemption
        if (enter0_s) begin
            state_d = OWN0;
            hold_d  = HOLD_LOAD;
            disp_d  = data0;
            ptr_d   = 1'b1;
        end else if (enter1_s) begin
            state_d = OWN1;
            hold_d  = HOLD_LOAD;
            disp_d  = data1;
            ptr_d   = 1'b0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State, hold counter, display register and pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= HOLD_ZERO;
            disp_q  <= 16'h0000;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            disp_q  <= disp_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant0 = (state_q == OWN0);
    assign grant1 = (state_q == OWN1);
    assign busy   = (state_q != IDLE);
    assign hex0   = disp_q[3:0];
    assign hex1   = disp_q[7:4];
    assign hex2   = disp_q[11:8];
    assign hex3   = disp_q[15:12];

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Self-checking bench for sseg_display_arbiter: directed literal checks plus randomized traffic against an ownership/age model.
module tb_sseg_display_arbiter;

`ifdef SSEG_ARB_PREEMPT_EN
    localparam int HOLD = 8;
    localparam bit PRE  = 1'b1;
`else
    localparam int HOLD = 4;
    localparam bit PRE  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, req0, req1;
    logic [15:0] data0, data1;
    logic        grant0, grant1, busy;
    logic [3:0]  hex0, hex1, hex2, hex3;

    int n_cmp = 0;
    int n_bad = 0;

    sseg_display_arbiter #(.HOLD_WIDTH(4), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .grant0(grant0), .grant1(grant1), .busy(busy),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
    );

    always #5 clk = ~clk;

    // Model: owner (0 none, 1 req0, 2 req1), age = cycles the current grant has been shown
    int          m_owner = 0, m_age = 0, m_ptr = 0;
    logic [15:0] m_disp = 16'h0000;
    bit          m_valid = 1'b0;
    int          nx_owner, nx_age, nx_ptr;
    logic [15:0] nx_disp;

    function automatic void model_next(
        input int o, input int a, input int p, input logic [15:0] d,
        input logic r, input logic q0, input logic q1,
        input logic [15:0] d0, input logic [15:0] d1,
        output int no, output int na, output int np, output logic [15:0] nd);
        int want, me;
        logic q_me, q_other;
        no = o; na = a; np = p; nd = d; want = -1;
        if (r) begin
            no = 0; na = 0; np = 0; nd = 16'h0000;
        end else begin
            if (o == 0) begin
                if (q0 && q1) want = PRE ? 1 : p;
                else if (q0) want = 0;
                else if (q1) want = 1;
            end else begin
                me      = o - 1;
                q_me    = (me == 1) ? q1 : q0;
                q_other = (me == 1) ? q0 : q1;
                nd      = (me == 1) ? d1 : d0;
                if (PRE && me == 0 && q1) want = 1;
                else if (a >= HOLD) begin
                    if (q_other) want = 1 - me;
                    else if (!q_me) no = 0;
                end
                if (a < HOLD) na = a + 1;
            end
            if (want >= 0) begin
                no = want + 1; na = 1; np = 1 - want;
                nd = (want == 1) ? d1 : d0;
            end
        end
    endfunction

    always_comb begin
        model_next(m_owner, m_age, m_ptr, m_disp, reset, req0, req1, data0, data1,
                   nx_owner, nx_age, nx_ptr, nx_disp);
    end

    always @(posedge clk) begin
        m_owner <= nx_owner;
        m_age   <= nx_age;
        m_ptr   <= nx_ptr;
        m_disp  <= nx_disp;
        if (reset) m_valid <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_grant0", 32'(grant0), 32'(m_owner == 1));
            check("model_grant1", 32'(grant1), 32'(m_owner == 2));
            check("model_busy",   32'(busy),   32'(m_owner != 0));
            check("model_hex",    32'({hex3, hex2, hex1, hex0}), 32'(m_disp));
            check("exclusive",    32'(grant0 & grant1), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic g0, input logic g1, input logic [15:0] hx);
        check({name, "_g0"},  32'(grant0), 32'(g0));
        check({name, "_g1"},  32'(grant1), 32'(g1));
        check({name, "_bsy"}, 32'(busy),   32'(g0 | g1));
        check({name, "_hex"}, 32'({hex3, hex2, hex1, hex0}), 32'(hx));
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 16'h0000; data1 = 16'h0000;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("idle", 1'b0, 1'b0, 16'h0000);
        end

`ifndef SSEG_ARB_PREEMPT_EN
        // Single requester, live tracking, then release after drop
        req0 = 1'b1; data0 = 16'h1234;
        tick(); expect_out("grant0_first", 1'b1, 1'b0, 16'h1234);
        data0 = 16'h0009;
        tick(); expect_out("track", 1'b1, 1'b0, 16'h0009);
        req0 = 1'b0;
        tick();
        tick(); expect_out("hold_last", 1'b1, 1'b0, 16'h0009);
        tick(); expect_out("release", 1'b0, 1'b0, 16'h0009);

        // Both requesting from reset: alternate every 4 cycles, requester 0 first
        reset = 1'b1;
        tick();
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1; data0 = 16'h0A0A; data1 = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out("rr_own0", 1'b1, 1'b0, 16'h0A0A);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out("rr_own1", 1'b0, 1'b1, 16'h5555);
        end
        tick(); expect_out("rr_back0", 1'b1, 1'b0, 16'h0A0A);

        // Reset on the 2nd cycle of an OWN1 grant
        repeat (3) tick();
        tick(); expect_out("own1_c1", 1'b0, 1'b1, 16'h5555);
        tick(); expect_out("own1_c2", 1'b0, 1'b1, 16'h5555);
        reset = 1'b1;
        tick(); expect_out("mid_reset", 1'b0, 1'b0, 16'h0000);
        reset = 1'b0;
        tick(); expect_out("post_reset", 1'b1, 1'b0, 16'h0A0A);
`else
        // Requester 1 preempts on the 2nd grant cycle and then holds HOLD cycles
        req0 = 1'b1; data0 = 16'h1111; data1 = 16'h2222;
        tick(); expect_out("pre_own0_c1", 1'b1, 1'b0, 16'h1111);
        tick(); expect_out("pre_own0_c2", 1'b1, 1'b0, 16'h1111);
        req1 = 1'b1;
        tick(); expect_out("preempt", 1'b0, 1'b1, 16'h2222);
        req1 = 1'b0;
        for (int i = 0; i < HOLD - 1; i++) begin
            tick(); expect_out("pre_hold1", 1'b0, 1'b1, 16'h2222);
        end
        tick(); expect_out("pre_back0", 1'b1, 1'b0, 16'h1111);
`endif

        // Randomized traffic checked by the model
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) req0 = ~req0;
            if ($urandom_range(0, 3) == 0) req1 = ~req1;
            if ($urandom_range(0, 1) == 0) data0 = 16'($urandom);
            if ($urandom_range(0, 1) == 0) data1 = 16'($urandom);
        end
        reset = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
